// File: rtl/bus_slave_mem_pkg.sv
// Shared bus constants and slave FSM state encoding. The bus master
// imports the same package so both ends agree on the frame layout.
package bus_pkg;

  localparam int ADDR_W         = 14;
  localparam int DATA_W         = 8;
  localparam int SLAVE_ID_W     = 2;
  localparam int DATA_START_BIT = 6;

  // Counter-width views of the frame layout, sized to match bit_cnt.
  localparam logic [3:0] CNT_DATA_START = 4'(DATA_START_BIT);
  localparam logic [3:0] CNT_LAST_ADDR  = 4'(ADDR_W - 1);
  localparam logic [3:0] CNT_LAST_DATA  = 4'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ADDR,
    S_WRITE,
    S_READ_MEM,
    S_RESP_VALID,
    S_RESP_DATA
  } slave_state_t;

  // Slave-select field carried in the top bits of a bus address.
  function automatic logic [SLAVE_ID_W-1:0] addr_id(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: SLAVE_ID_W];
  endfunction

endpackage

// File: rtl/bus_slave_mem_if.sv
// Serial bus between the master and one slave: frame, address, write data
// and write strobe towards the slave, response and status back.
interface bus_slave_mem_if;

  logic valid_s;
  logic addr_tx;
  logic data_tx;
  logic write_en_slave;
  logic data_rx;
  logic slave_valid;
  logic slave_ready;
  logic slave_busy;

  modport master (
    output valid_s, addr_tx, data_tx, write_en_slave,
    input  data_rx, slave_valid, slave_ready, slave_busy
  );

  modport slave (
    input  valid_s, addr_tx, data_tx, write_en_slave,
    output data_rx, slave_valid, slave_ready, slave_busy
  );

endinterface

// File: rtl/bus_slave_mem_ram.sv
// Single-port synchronous byte RAM with a registered read port.
// A write also returns the written byte on the read port (write-first).
module slave_ram #(
  parameter int MEM_AW = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1 << MEM_AW) - 1];
  logic [DATA_W-1:0] rdata_q;

  // Storage update and registered read; write-first on the read port.
  // NOTE: the array and read register have no reset so the tools can map
  // them onto block RAM; contents are undefined until first written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_q       <= wdata_i;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_slave_mem.sv
// Serial bus slave: deserialises a 14-bit address and 8-bit write data,
// stores writes in a local RAM and serialises read data back to the
// master behind a one-cycle slave_valid marker.
module bus_slave_mem
  import bus_pkg::*;
#(
  parameter logic [SLAVE_ID_W-1:0] SLAVE_ID = '0,
  parameter int                    MEM_AW   = 12
) (
  input logic            clock,
  input logic            reset,
  bus_slave_mem_if.slave bus
);

  slave_state_t      state_q;
  logic [3:0]        bit_cnt_q;
  logic [ADDR_W-1:0] addr_sr_q;
  logic [ADDR_W-1:0] addr_sr_d;
  logic [DATA_W-1:0] data_sr_q;
  logic [DATA_W-1:0] data_sr_d;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rd_data;
  logic              is_write_q;
  logic              data_rx_q;
  logic              slave_valid_q;
  logic              slave_ready_q;
  logic              id_hit_d;
  logic              ram_we;
  logic [MEM_AW-1:0] ram_addr;

  // Shift registers as they will look after this cycle's sample.
  assign addr_sr_d = {addr_sr_q[ADDR_W-2:0], bus.addr_tx};
  assign data_sr_d = {data_sr_q[DATA_W-2:0], bus.data_tx};
  assign id_hit_d  = (addr_id(addr_sr_d) == SLAVE_ID);

  // During the address phase the RAM is addressed with the incoming shift
  // value, so the read issued on the final address bit is already in
  // rd_data when READ_MEM runs; afterwards the captured address holds.
  assign ram_addr = (state_q == S_RX_ADDR) ? addr_sr_d[MEM_AW-1:0]
                                           : addr_sr_q[MEM_AW-1:0];

  // A write coinciding with reset is dropped.
  assign ram_we = (state_q == S_WRITE) && is_write_q &&
                  (addr_id(addr_sr_q) == SLAVE_ID) && !reset;

  slave_ram #(
    .MEM_AW (MEM_AW),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (data_sr_q),
    .rdata_o (rd_data)
  );

  // Transaction FSM with its shift registers, counter and registered outputs.
  // NOTE: every assignment here is non-blocking so all registers update
  // together from the values present before the clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      addr_sr_q     <= '0;
      data_sr_q     <= '0;
      tx_sr_q       <= '0;
      is_write_q    <= 1'b0;
      data_rx_q     <= 1'b0;
      slave_valid_q <= 1'b0;
      slave_ready_q <= 1'b1;
    end else begin
      // Response outputs are idle unless a state below drives them.
      data_rx_q     <= 1'b0;
      slave_valid_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          bit_cnt_q <= '0;
          if (bus.valid_s) begin
            state_q       <= S_RX_ADDR;
            slave_ready_q <= 1'b0;
          end
        end

        S_RX_ADDR: begin
          if (!bus.valid_s) begin
            // Frame dropped by the master: discard this bit, write nothing.
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            slave_ready_q <= 1'b1;
          end else begin
            addr_sr_q <= addr_sr_d;
            if (bit_cnt_q >= CNT_DATA_START) begin
              data_sr_q <= data_sr_d;
            end
            if (bit_cnt_q == CNT_LAST_ADDR) begin
              // Last address bit: latch direction and decode the slave ID.
              is_write_q <= bus.write_en_slave;
              bit_cnt_q  <= '0;
              if (!id_hit_d) begin
                state_q       <= S_IDLE;
                slave_ready_q <= 1'b1;
              end else if (bus.write_en_slave) begin
                state_q <= S_WRITE;
              end else begin
                state_q <= S_READ_MEM;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end

        S_WRITE: begin
          // The RAM write strobe is decoded from this state.
          state_q       <= S_IDLE;
          slave_ready_q <= 1'b1;
        end

        S_READ_MEM: begin
          tx_sr_q       <= rd_data;
          slave_valid_q <= 1'b1;
          state_q       <= S_RESP_VALID;
        end

        S_RESP_VALID: begin
          // Pre-load the MSB so it is on data_rx the cycle after slave_valid.
          data_rx_q <= tx_sr_q[DATA_W-1];
          tx_sr_q   <= {tx_sr_q[DATA_W-2:0], 1'b0};
          bit_cnt_q <= '0;
          state_q   <= S_RESP_DATA;
        end

        S_RESP_DATA: begin
          if (bit_cnt_q == CNT_LAST_DATA) begin
            // Bit 0 is on the wire this cycle; return to IDLE after it.
            bit_cnt_q     <= '0;
            state_q       <= S_IDLE;
            slave_ready_q <= 1'b1;
          end else begin
            data_rx_q <= tx_sr_q[DATA_W-1];
            tx_sr_q   <= {tx_sr_q[DATA_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end

        default: begin
          state_q       <= S_IDLE;
          bit_cnt_q     <= '0;
          slave_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.data_rx     = data_rx_q;
  assign bus.slave_valid = slave_valid_q;
  assign bus.slave_ready = slave_ready_q;
  assign bus.slave_busy  = ~slave_ready_q;

endmodule
